cavlc_stage_sequencer: RTL and testbench
========================================

CAVLC_STAGE_SEQUENCER -- requirements
Module: cavlc_stage_sequencer

Interface
REQ-001 SHALL have parameter NZQ_WIDTH, default 5: width of NZQ and total_zeros inputs.
REQ-002 SHALL have parameter BITCNT_WIDTH, default 10: width of bit_count output.
REQ-003 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start_block, input, 1: request to encode one 4x4 block.
REQ-006 SHALL have port NZQ, input, NZQ_WIDTH: nonzero coefficient count, 0..16.
REQ-007 SHALL have port T1s, input, 2: trailing-ones count, 0..3.
REQ-008 SHALL have port total_zeros, input, NZQ_WIDTH: zeros before the last nonzero coefficient, 0..15.
REQ-009 SHALL have port stage_start, output, 5: one-hot start pulse; bit0 coeff_token, bit1 T1 signs, bit2 levels, bit3 total_zeros, bit4 run_before.
REQ-010 SHALL have port stage_finish, input, 5: per-stage finish pulse, same bit mapping.
REQ-011 SHALL have ports stage_fifo_data and stage_fifo_push, input, 5 each: per-stage serial bit and push strobe.
REQ-012 SHALL have port fifo_full, input, 1: output FIFO full.
REQ-013 SHALL have port stage_hold, output, 1: stall request to the active stage.
REQ-014 SHALL have ports o_fifo_data and o_fifo_push, output, 1 each: arbitrated serial bit and push to the output FIFO.
REQ-015 SHALL have port busy, output, 1: high from acceptance of start_block until done.
REQ-016 SHALL have port done, output, 1: one-cycle pulse at block completion.
REQ-017 SHALL have port bit_count, output, BITCNT_WIDTH: bits pushed for the current or last block.
REQ-018 SHALL have port protocol_err, output, 1: sticky protocol violation flag.

Function
REQ-019 SHALL implement FSM states IDLE, SEL, ISSUE, WAIT, DONE.
REQ-020 SHALL in IDLE, on start_block=1: latch NZQ, T1s, total_zeros; clear bit_count; set busy; go to SEL next cycle.
REQ-021 SHALL ignore start_block when not in IDLE; no error flagged.
REQ-022 SHALL in SEL pick the lowest-index stage, above the last completed stage, whose enable is true, and go to ISSUE; if none, go to DONE.
REQ-023 SHALL use stage enables: coeff_token always; T1 signs if T1s!=0; levels if NZQ>T1s; total_zeros if 0<NZQ<16; run_before if NZQ>1 and total_zeros!=0.
REQ-024 SHALL in ISSUE assert stage_start for the selected stage for exactly one cycle, then go to WAIT.
REQ-025 SHALL in WAIT stay until stage_finish of the active stage is 1, then go to SEL.
REQ-026 SHALL give a SEL-to-SEL overhead of 2 cycles plus the stage duration.
REQ-027 SHALL drive o_fifo_data equal to the active stage's data bit, combinationally, in ISSUE and WAIT.
REQ-028 SHALL drive o_fifo_push = active stage push AND NOT fifo_full in ISSUE and WAIT; 0 in all other states.
REQ-029 SHALL drive stage_hold = fifo_full while busy; 0 otherwise.
REQ-030 SHALL increment bit_count on every cycle o_fifo_push=1 and saturate at all-ones.
REQ-031 SHALL forward a push and act on a finish from the active stage in the same cycle.
REQ-032 SHALL set protocol_err on any of: push or finish from a non-active stage; push while fifo_full=1; NZQ>16 or T1s>NZQ at latch.
REQ-033 SHALL drop offending pushes, not forward them, and keep the FSM running.
REQ-034 SHALL in DONE pulse done for one cycle, clear busy, hold bit_count, and return to IDLE.
REQ-035 SHALL accept start_block in IDLE in the cycle right after DONE.

Reset
REQ-036 SHALL on rst=1 at a clock edge: FSM to IDLE; stage_start, o_fifo_push, stage_hold, busy, done to 0; bit_count to 0; protocol_err to 0; latched registers to 0.
REQ-037 SHALL let rst override every other input, including mid-block; after reset, no stage_start until a new start_block.
REQ-038 SHALL drive o_fifo_data 0 in reset and IDLE.

Verification
REQ-039 SHALL test NZQ=0, T1s=0 -> only stage_start[0]; after finish[0], done 2 cycles later; bit_count equals bits pushed.
REQ-040 SHALL test NZQ=5, T1s=2, total_zeros=3 -> starts issued in order 0,1,2,3,4; each start is 2 cycles after the previous finish.
REQ-041 SHALL test NZQ=16, T1s=3, total_zeros=0 -> stages 0,1,2 only; stages 3 and 4 never started.
REQ-042 SHALL test fifo_full=1 for 4 cycles in stage 2 WAIT while the stage pushes -> stage_hold=1, o_fifo_push=0, protocol_err=1, bit_count unchanged during that window.
REQ-043 SHALL test finish[3] while stage 1 is active -> protocol_err=1, FSM still waits for finish[1].
REQ-044 SHALL test rst=1 during stage 2 WAIT -> next cycle IDLE, busy=0, bit_count=0; a new start_block with NZQ=1, T1s=1 gives stages 0, 1, 3.

Source files
------------

// File: rtl/cavlc_stage_sequencer.sv
// Sequences the five CAVLC encoding stages for one 4x4 block, arbitrates their
// serial output onto a single FIFO port, counts forwarded bits and flags protocol misuse.
module cavlc_stage_sequencer #(
    parameter int NZQ_WIDTH    = 5,
    parameter int BITCNT_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_block,
    input  logic [NZQ_WIDTH-1:0]    NZQ,
    input  logic [1:0]              T1s,
    input  logic [NZQ_WIDTH-1:0]    total_zeros,
    output logic [4:0]              stage_start,
    input  logic [4:0]              stage_finish,
    input  logic [4:0]              stage_fifo_data,
    input  logic [4:0]              stage_fifo_push,
    input  logic                    fifo_full,
    output logic                    stage_hold,
    output logic                    o_fifo_data,
    output logic                    o_fifo_push,
    output logic                    busy,
    output logic                    done,
    output logic [BITCNT_WIDTH-1:0] bit_count,
    output logic                    protocol_err
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SEL   = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]              state_q, state_d;
    logic [NZQ_WIDTH-1:0]    nzq_q, nzq_d;
    logic [1:0]              t1s_q, t1s_d;
    logic [NZQ_WIDTH-1:0]    tz_q, tz_d;
    logic [2:0]              active_q, active_d;
    logic [2:0]              next_q, next_d;
    logic [BITCNT_WIDTH-1:0] bit_count_q, bit_count_d;
    logic                    err_q, err_d;

    logic [4:0] stage_en;
    logic       sel_found;
    logic [2:0] sel_idx;
    logic       active_phase;
    logic [4:0] active_mask;
    logic       act_push, act_data, act_finish;
    logic       rogue, full_push, latch_bad;

    assign stage_en[0] = 1'b1;
    assign stage_en[1] = (t1s_q != 2'd0);
    assign stage_en[2] = (nzq_q > NZQ_WIDTH'(t1s_q));
    assign stage_en[3] = (nzq_q != '0) && (nzq_q < NZQ_WIDTH'(16));
    assign stage_en[4] = (nzq_q > NZQ_WIDTH'(1)) && (tz_q != '0);

    // next_q is the lowest stage index still eligible; descending scan lets the lowest hit win.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (stage_en[i] && (3'(i) >= next_q)) begin
                sel_found = 1'b1;
                sel_idx   = 3'(i);
            end
        end
    end

    assign active_phase = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign active_mask  = active_phase ? (5'b00001 << active_q) : 5'b00000;
    assign act_push     = |(stage_fifo_push & active_mask);
    assign act_data     = |(stage_fifo_data & active_mask);
    assign act_finish   = |(stage_finish & active_mask);

    assign stage_start  = (state_q == ST_ISSUE) ? active_mask : 5'b00000;
    assign o_fifo_data  = act_data;
    assign o_fifo_push  = act_push & ~fifo_full;
    assign busy         = (state_q == ST_SEL) || active_phase;
    assign stage_hold   = busy & fifo_full;
    assign done         = (state_q == ST_DONE);
    assign bit_count    = bit_count_q;
    assign protocol_err = err_q;

    assign rogue     = |((stage_fifo_push | stage_finish) & ~active_mask);
    assign full_push = (|stage_fifo_push) & fifo_full;
    assign latch_bad = (state_q == ST_IDLE) && start_block &&
                       ((NZQ > NZQ_WIDTH'(16)) || (NZQ_WIDTH'(T1s) > NZQ));

    always_comb begin
        state_d     = state_q;
        nzq_d       = nzq_q;
        t1s_d       = t1s_q;
        tz_d        = tz_q;
        active_d    = active_q;
        next_d      = next_q;
        bit_count_d = bit_count_q;
        err_d       = err_q | rogue | full_push | latch_bad;

        if (o_fifo_push && (bit_count_q != '1)) begin
            bit_count_d = bit_count_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_block) begin
                    nzq_d       = NZQ;
                    t1s_d       = T1s;
                    tz_d        = total_zeros;
                    next_d      = 3'd0;
                    bit_count_d = '0;
                    state_d     = ST_SEL;
                end
            end
            ST_SEL: begin
                if (sel_found) begin
                    active_d = sel_idx;
                    state_d  = ST_ISSUE;
                end else begin
                    state_d  = ST_DONE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (act_finish) begin
                    next_d  = active_q + 3'd1;
                    state_d = ST_SEL;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            nzq_q       <= '0;
            t1s_q       <= '0;
            tz_q        <= '0;
            active_q    <= '0;
            next_q      <= '0;
            bit_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            nzq_q       <= nzq_d;
            t1s_q       <= t1s_d;
            tz_q        <= tz_d;
            active_q    <= active_d;
            next_q      <= next_d;
            bit_count_q <= bit_count_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_cavlc_stage_sequencer.sv
// Scoreboard bench: the driver queues expected starts, forwarded bits and final bit counts;
// a negedge monitor pops and compares them whenever the sequencer presents an output.
module tb_cavlc_stage_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_block = 1'b0;
    logic [4:0] NZQ = '0;
    logic [1:0] T1s = '0;
    logic [4:0] total_zeros = '0;
    logic [4:0] stage_start;
    logic [4:0] stage_finish = '0;
    logic [4:0] stage_fifo_data = '0;
    logic [4:0] stage_fifo_push = '0;
    logic       fifo_full = 1'b0;
    logic       stage_hold, o_fifo_data, o_fifo_push, busy, done, protocol_err;
    logic [9:0] bit_count;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int mark_cyc = 0;
    int cur_stage = -1;
    int mk;

    int   exp_start[$];
    logic exp_bit[$];
    int   exp_cnt[$];

    cavlc_stage_sequencer #(.NZQ_WIDTH(5), .BITCNT_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .start_block(start_block), .NZQ(NZQ), .T1s(T1s),
        .total_zeros(total_zeros), .stage_start(stage_start), .stage_finish(stage_finish),
        .stage_fifo_data(stage_fifo_data), .stage_fifo_push(stage_fifo_push),
        .fifo_full(fifo_full), .stage_hold(stage_hold), .o_fifo_data(o_fifo_data),
        .o_fifo_push(o_fifo_push), .busy(busy), .done(done), .bit_count(bit_count),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every start, forwarded bit and done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (start_block && !busy && !done) mark_cyc = cyc;
            if (stage_start != 5'd0) begin
                if (exp_start.size() == 0) begin
                    check("unexpected_start", 32'(stage_start), 0);
                end else begin
                    mk = exp_start.pop_front();
                    check("start_stage", 32'(stage_start), 32'(1 << mk));
                    check("start_gap", cyc - mark_cyc, 2);
                    cur_stage = mk;
                end
            end
            if (cur_stage >= 0 && stage_finish[cur_stage]) begin
                mark_cyc  = cyc;
                cur_stage = -1;
            end
            if (o_fifo_push) begin
                if (exp_bit.size() == 0) check("unexpected_push", 32'(o_fifo_push), 0);
                else check("fifo_bit", 32'(o_fifo_data), 32'(exp_bit.pop_front()));
            end
            if (done) begin
                if (exp_cnt.size() == 0) begin
                    check("unexpected_done", 32'(done), 0);
                end else begin
                    check("done_bit_count", 32'(bit_count), exp_cnt.pop_front());
                    check("done_gap", cyc - mark_cyc, 2);
                    check("done_busy", 32'(busy), 0);
                end
            end
        end
    end

    task automatic start(input logic [4:0] nzq, input logic [1:0] t1, input logic [4:0] tz);
        NZQ = nzq; T1s = t1; total_zeros = tz;
        start_block = 1'b1;
        @(posedge clk); #1;
        start_block = 1'b0;
        @(negedge clk);
        check("busy_after_start", 32'(busy), 1);
    endtask

    task automatic wait_start(input int k);
        logic seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = stage_start[k];
        end
        check($sformatf("start_seen_s%0d", k), 32'(seen), 1);
        @(posedge clk); #1;
    endtask

    task automatic run_stage(input int k, input int n, input logic [15:0] bits);
        exp_start.push_back(k);
        wait_start(k);
        for (int i = 0; i < n; i++) begin
            stage_fifo_push[k] = 1'b1;
            stage_fifo_data[k] = bits[i];
            exp_bit.push_back(bits[i]);
            if (i == n - 1) stage_finish[k] = 1'b1;
            @(posedge clk); #1;
        end
        if (n == 0) begin
            stage_finish[k] = 1'b1;
            @(posedge clk); #1;
        end
        stage_fifo_push = '0; stage_fifo_data = '0; stage_finish = '0;
    endtask

    task automatic wait_done();
        logic seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        check("done_seen", 32'(seen), 1);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stage_start", 32'(stage_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_bit_count", 32'(bit_count), 0);
        check("rst_protocol_err", 32'(protocol_err), 0);
        check("rst_fifo_data", 32'(o_fifo_data), 0);
        check("rst_fifo_push", 32'(o_fifo_push), 0);
        @(posedge clk); #1;

        // Empty block: coeff_token only, 3 bits.
        exp_cnt.push_back(3);
        start(5'd0, 2'd0, 5'd0);
        run_stage(0, 3, 16'b101);
        wait_done();

        // All five stages, started right after the previous DONE: 4+2+6+3+5 bits.
        exp_cnt.push_back(20);
        start(5'd5, 2'd2, 5'd3);
        run_stage(0, 4, 16'b1101);
        run_stage(1, 2, 16'b10);
        run_stage(2, 6, 16'b011001);
        run_stage(3, 3, 16'b100);
        run_stage(4, 5, 16'b10110);
        wait_done();
        check("err_clean_blocks", 32'(protocol_err), 0);

        // Full block: total_zeros and run_before skipped, 2+3+4 bits.
        exp_cnt.push_back(9);
        start(5'd16, 2'd3, 5'd0);
        run_stage(0, 2, 16'b01);
        run_stage(1, 3, 16'b111);
        run_stage(2, 4, 16'b1001);
        wait_done();

        // FIFO full for 4 cycles while stage 2 keeps pushing.
        exp_cnt.push_back(16);
        start(5'd5, 2'd2, 5'd3);
        run_stage(0, 4, 16'b0110);
        run_stage(1, 2, 16'b01);
        exp_start.push_back(2);
        wait_start(2);
        stage_fifo_push[2] = 1'b1; stage_fifo_data[2] = 1'b1; exp_bit.push_back(1'b1);
        @(posedge clk); #1;
        fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full_stage_hold", 32'(stage_hold), 1);
            check("full_no_push", 32'(o_fifo_push), 0);
            check("full_bit_count", 32'(bit_count), 7);
            @(posedge clk); #1;
        end
        fifo_full = 1'b0;
        stage_fifo_data[2] = 1'b0; stage_finish[2] = 1'b1; exp_bit.push_back(1'b0);
        @(posedge clk); #1;
        stage_fifo_push = '0; stage_fifo_data = '0; stage_finish = '0;
        @(negedge clk);
        check("full_protocol_err", 32'(protocol_err), 1);
        run_stage(3, 3, 16'b011);
        run_stage(4, 5, 16'b00111);
        wait_done();
        fifo_full = 1'b1;
        @(negedge clk);
        check("idle_stage_hold", 32'(stage_hold), 0);
        @(posedge clk); #1;
        fifo_full = 1'b0;

        // Stray finish from stage 3 while stage 1 is active.
        pulse_reset();
        @(negedge clk);
        check("err_cleared_by_rst", 32'(protocol_err), 0);
        @(posedge clk); #1;
        exp_cnt.push_back(6);
        start(5'd5, 2'd2, 5'd3);
        run_stage(0, 2, 16'b10);
        exp_start.push_back(1);
        wait_start(1);
        stage_finish[3] = 1'b1;
        @(posedge clk); #1;
        stage_finish = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_err", 32'(protocol_err), 1);
            check("stray_still_busy", 32'(busy), 1);
            check("stray_no_start", 32'(stage_start), 0);
            @(posedge clk); #1;
        end
        stage_fifo_push[1] = 1'b1; stage_finish[1] = 1'b1; exp_bit.push_back(1'b0);
        @(posedge clk); #1;
        stage_fifo_push = '0; stage_finish = '0;
        run_stage(2, 1, 16'b1);
        run_stage(3, 1, 16'b0);
        run_stage(4, 1, 16'b1);
        wait_done();

        // Reset in the middle of stage 2, then a fresh NZQ=1, T1s=1 block.
        pulse_reset();
        start(5'd5, 2'd2, 5'd3);
        run_stage(0, 1, 16'b1);
        run_stage(1, 1, 16'b0);
        exp_start.push_back(2);
        wait_start(2);
        stage_fifo_push[2] = 1'b1; stage_fifo_data[2] = 1'b1; exp_bit.push_back(1'b1);
        @(posedge clk); #1;
        stage_fifo_data[2] = 1'b0; exp_bit.push_back(1'b0);
        @(posedge clk); #1;
        stage_fifo_push = '0; stage_fifo_data = '0;
        pulse_reset();
        @(negedge clk);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_bit_count", 32'(bit_count), 0);
        check("midrst_fifo_data", 32'(o_fifo_data), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midrst_no_start", 32'(stage_start), 0);
        end
        @(posedge clk); #1;
        exp_cnt.push_back(4);
        start(5'd1, 2'd1, 5'd0);
        run_stage(0, 1, 16'b1);
        run_stage(1, 1, 16'b1);
        run_stage(3, 2, 16'b01);
        wait_done();
        check("err_after_clean_block", 32'(protocol_err), 0);

        // T1s greater than NZQ at latch: flagged, stages 0, 1, 3 still run.
        exp_cnt.push_back(3);
        start(5'd2, 2'd3, 5'd0);
        run_stage(0, 1, 16'b0);
        run_stage(1, 1, 16'b1);
        run_stage(3, 1, 16'b1);
        wait_done();
        check("bad_latch_err", 32'(protocol_err), 1);

        repeat (3) @(posedge clk);
        check("queues_drained", exp_start.size() + exp_bit.size() + exp_cnt.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
